// File: rtl/alu_iterative.sv
// alu_iterative
//   Execution-stage ALU. AND/OR/ADD/SUB and the illegal codes complete in a
//   single clock. MUL is an iterative shift-add taking WIDTH clocks, during
//   which busy_o lets the pipeline stall the EX stage. The result and zero
//   flag are registered for the MEM stage and hold until the next completion.
//
// Ports
//   clk_i      in   1      clock, rising edge
//   rst_i      in   1      asynchronous, active-high reset
//   start_i    in   1      operation request, sampled only in IDLE
//   ALUCtrl_i  in   3      000 AND, 001 OR, 010 ADD, 110 SUB, 111 MUL
//   data0_i    in   WIDTH  operand A (rs)
//   data1_i    in   WIDTH  operand B (rt / immediate)
//   data_o     out  WIDTH  registered result
//   zero_o     out  1      registered (data_o == 0)
//   busy_o     out  1      high while a MUL is in progress
//   done_o     out  1      one-cycle pulse after data_o/zero_o update
module alu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [WIDTH-1:0] data1_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             done_o
);

  // Counter must be able to hold the value WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0] mcand, mcand_next;
  logic [WIDTH-1:0] mplier, mplier_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] data_next;
  logic             zero_next;
  logic             done_next;
  logic [WIDTH-1:0] single_result;
  logic [WIDTH-1:0] partial_sum;

  // Single-cycle datapath; illegal codes produce zero.
  always_comb begin
    single_result = '0;
    case (ALUCtrl_i)
      OP_AND:  single_result = data0_i & data1_i;
      OP_OR:   single_result = data0_i | data1_i;
      OP_ADD:  single_result = data0_i + data1_i;
      OP_SUB:  single_result = data0_i - data1_i;
      default: single_result = '0;
    endcase
  end

  // One shift-add step. Only the low WIDTH bits are kept, which is why the
  // result is the same for signed and unsigned operands.
  assign partial_sum = acc + (mplier[0] ? mcand : '0);

  // Next-state and datapath-register logic.
  always_comb begin
    state_next  = state;
    acc_next    = acc;
    mcand_next  = mcand;
    mplier_next = mplier;
    cnt_next    = cnt;
    data_next   = data_o;
    zero_next   = zero_o;
    done_next   = 1'b0;

    case (state)
      IDLE: begin
        if (start_i) begin
          if (ALUCtrl_i == OP_MUL) begin
            acc_next    = '0;
            mcand_next  = data0_i;
            mplier_next = data1_i;
            cnt_next    = '0;
            state_next  = MUL;
          end else begin
            data_next = single_result;
            zero_next = (single_result == '0);
            done_next = 1'b1;
          end
        end
      end
      MUL: begin
        // start_i and operand changes are ignored here.
        acc_next    = partial_sum;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
        cnt_next    = cnt + CW'(1);
        // The final step's sum goes straight to the output so completion
        // lands on the same edge where the counter reaches WIDTH.
        if (cnt == LAST_STEP) begin
          data_next  = partial_sum;
          zero_next  = (partial_sum == '0);
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers. Reset aborts any MUL with no done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      data_o <= '0;
      zero_o <= 1'b1;
      done_o <= 1'b0;
    end else begin
      state  <= state_next;
      acc    <= acc_next;
      mcand  <= mcand_next;
      mplier <= mplier_next;
      cnt    <= cnt_next;
      data_o <= data_next;
      zero_o <= zero_next;
      done_o <= done_next;
    end
  end

  assign busy_o = (state == MUL);

endmodule

// File: tb/tb_alu_iterative.sv
// tb_alu_iterative
//   Directed bench for alu_iterative with hand-computed expected values.
//   Inputs are changed 1 ns after a rising edge and outputs are sampled at
//   that same point, away from the active edge.
module tb_alu_iterative;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] data;
  logic        zero;
  logic        busy;
  logic        done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_iterative #(.WIDTH(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .ALUCtrl_i (ctrl),
    .data0_i   (a),
    .data1_i   (b),
    .data_o    (data),
    .zero_o    (zero),
    .busy_o    (busy),
    .done_o    (done)
  );

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Present a request for exactly one rising edge.
  task automatic applyStimulus(input logic [2:0] c, input logic [31:0] x,
                               input logic [31:0] y);
    start = 1'b1;
    ctrl  = c;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  // Count edges until busy drops, bounded so a stuck DUT cannot hang us.
  task automatic waitMulDone(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    int dones;
    logic [31:0] captured;

    rst   = 1'b1;
    start = 1'b0;
    ctrl  = 3'b000;
    a     = '0;
    b     = '0;

    // Reset state
    #12;
    checkOutput("reset_data", data, 32'h0);
    checkOutput("reset_zero", {31'b0, zero}, 32'h1);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_done", {31'b0, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idleCycle();

    // ADD 5+7
    applyStimulus(3'b010, 32'd5, 32'd7);
    checkOutput("add_data", data, 32'd12);
    checkOutput("add_zero", {31'b0, zero}, 32'h0);
    checkOutput("add_done", {31'b0, done}, 32'h1);
    checkOutput("add_busy", {31'b0, busy}, 32'h0);
    idleCycle();
    checkOutput("add_done_pulse", {31'b0, done}, 32'h0);
    checkOutput("add_hold", data, 32'd12);

    // SUB 3-3
    applyStimulus(3'b110, 32'd3, 32'd3);
    checkOutput("sub_data", data, 32'h0);
    checkOutput("sub_zero", {31'b0, zero}, 32'h1);
    checkOutput("sub_done", {31'b0, done}, 32'h1);
    checkOutput("sub_busy", {31'b0, busy}, 32'h0);

    // Wrap-around cases
    applyStimulus(3'b110, 32'd0, 32'd1);
    checkOutput("sub_wrap", data, 32'hFFFF_FFFF);
    checkOutput("sub_wrap_zero", {31'b0, zero}, 32'h0);
    applyStimulus(3'b010, 32'hFFFF_FFFF, 32'd1);
    checkOutput("add_wrap", data, 32'h0);
    checkOutput("add_wrap_zero", {31'b0, zero}, 32'h1);

    // Logic ops
    applyStimulus(3'b000, 32'hF0F0_1234, 32'h0FF0_FF00);
    checkOutput("and_data", data, 32'h00F0_1200);
    applyStimulus(3'b001, 32'hF000_0000, 32'h0000_000F);
    checkOutput("or_data", data, 32'hF000_000F);

    // MUL 0xFFFFFFFF * 3
    applyStimulus(3'b111, 32'hFFFF_FFFF, 32'd3);
    checkOutput("mul1_busy", {31'b0, busy}, 32'h1);
    checkOutput("mul1_no_done", {31'b0, done}, 32'h0);
    checkOutput("mul1_hold", data, 32'hF000_000F);
    waitMulDone(cyc);
    checkOutput("mul1_cycles", cyc, 32'd32);
    checkOutput("mul1_data", data, 32'hFFFF_FFFD);
    checkOutput("mul1_zero", {31'b0, zero}, 32'h0);
    checkOutput("mul1_done", {31'b0, done}, 32'h1);
    idleCycle();
    checkOutput("mul1_done_pulse", {31'b0, done}, 32'h0);

    // MUL 0x10000 * 0x10000 truncates to zero
    applyStimulus(3'b111, 32'h0001_0000, 32'h0001_0000);
    waitMulDone(cyc);
    checkOutput("mul2_cycles", cyc, 32'd32);
    checkOutput("mul2_data", data, 32'h0);
    checkOutput("mul2_zero", {31'b0, zero}, 32'h1);

    // Start during MUL is ignored: 5*9 with an ADD 1+1 offered at cycle 5
    applyStimulus(3'b111, 32'd5, 32'd9);
    dones    = 0;
    captured = '0;
    for (int k = 0; k < 4; k++) begin
      idleCycle();
      if (done === 1'b1) dones++;
    end
    start = 1'b1;
    ctrl  = 3'b010;
    a     = 32'd1;
    b     = 32'd1;
    idleCycle();
    if (done === 1'b1) dones++;
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      idleCycle();
      if (done === 1'b1) begin
        dones++;
        captured = data;
      end
    end
    checkOutput("ignore_dones", dones, 32'd1);
    checkOutput("ignore_data", captured, 32'd45);
    checkOutput("ignore_final", data, 32'd45);

    // Reset in cycle 10 of a MUL
    applyStimulus(3'b111, 32'h0000_1234, 32'h0000_0010);
    for (int k = 0; k < 9; k++) idleCycle();
    checkOutput("rstmul_busy_before", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("rstmul_data", data, 32'h0);
    checkOutput("rstmul_zero", {31'b0, zero}, 32'h1);
    checkOutput("rstmul_busy", {31'b0, busy}, 32'h0);
    checkOutput("rstmul_done", {31'b0, done}, 32'h0);
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      idleCycle();
      if (done === 1'b1) dones++;
    end
    checkOutput("rstmul_no_done", dones, 32'd0);
    checkOutput("rstmul_idle_data", data, 32'h0);
    applyStimulus(3'b010, 32'd2, 32'd2);
    checkOutput("post_rst_add", data, 32'd4);
    checkOutput("post_rst_done", {31'b0, done}, 32'h1);

    // Back-to-back: MUL 3*3, then MUL 6*7 issued in its done cycle
    applyStimulus(3'b111, 32'd3, 32'd3);
    waitMulDone(cyc);
    checkOutput("b2b_first_data", data, 32'd9);
    checkOutput("b2b_first_done", {31'b0, done}, 32'h1);
    applyStimulus(3'b111, 32'd6, 32'd7);
    checkOutput("b2b_accept_busy", {31'b0, busy}, 32'h1);
    checkOutput("b2b_accept_done", {31'b0, done}, 32'h0);
    waitMulDone(cyc);
    checkOutput("b2b_cycles", cyc, 32'd32);
    checkOutput("b2b_data", data, 32'd42);
    checkOutput("b2b_done", {31'b0, done}, 32'h1);

    // Illegal 011 issued in the done cycle
    applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("ill011_data", data, 32'h0);
    checkOutput("ill011_zero", {31'b0, zero}, 32'h1);
    checkOutput("ill011_done", {31'b0, done}, 32'h1);
    checkOutput("ill011_busy", {31'b0, busy}, 32'h0);

    // Remaining illegal codes, each after a non-zero result
    applyStimulus(3'b010, 32'd1, 32'd1);
    checkOutput("pre100_data", data, 32'd2);
    applyStimulus(3'b100, 32'd8, 32'd8);
    checkOutput("ill100_data", data, 32'h0);
    checkOutput("ill100_zero", {31'b0, zero}, 32'h1);
    applyStimulus(3'b001, 32'h0000_00A0, 32'h0000_0005);
    checkOutput("pre101_data", data, 32'h0000_00A5);
    applyStimulus(3'b101, 32'd8, 32'd8);
    checkOutput("ill101_data", data, 32'h0);
    checkOutput("ill101_done", {31'b0, done}, 32'h1);

    // Idle hold
    idleCycle();
    checkOutput("idle_done", {31'b0, done}, 32'h0);
    checkOutput("idle_hold", data, 32'h0);
    checkOutput("idle_busy", {31'b0, busy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
